// File: rtl/itcm_arb_pkg.sv
// Shared types for the ITCM arbiter: requester identifiers carried through the in-order ID FIFO.
package itcm_arb_pkg;
  localparam int ID_W = 1;

  typedef enum logic [ID_W-1:0] {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered ITCM transactions.
module arb_id_fifo
  import itcm_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    aclk,
  input  logic    aresetn,
  input  logic    i_push,
  input  req_id_t i_push_id,
  input  logic    i_pop,
  output req_id_t o_head,
  output logic    o_full,
  output logic    o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says they are valid.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_id;
  end
endmodule

// File: rtl/itcm_arbiter.sv
// Shares the single-port ITCM between I-fetch and D/loader paths with in-order response routing.
// Optional D-side starvation guard enabled by defining ITCM_ARB_STARVE_EN.
module itcm_arbiter
  import itcm_arb_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        tcm_req,
  output logic        tcm_we,
  output logic [3:0]  tcm_be,
  output logic [31:0] tcm_addr,
  output logic [31:0] tcm_wdata,
  input  logic        tcm_gnt,
  input  logic        tcm_rvalid,
  input  logic [31:0] tcm_rdata,
  output logic        rsp_err
);
  if (OUTSTANDING < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("itcm_arbiter: OUTSTANDING and STARVE_LIMIT must be >= 1");
  end

  logic    w_full;
  logic    w_empty;
  req_id_t w_head;
  logic    w_starve;
  logic    w_sel_i;
  logic    w_sel_d;
  logic    w_hs;
  logic    w_pop;
  logic    w_spurious;
  logic    r_rsp_err;

  // Combinational outputs are gated by aresetn so everything reads 0 while in reset.
  assign w_sel_d = aresetn & d_req & (~i_req | w_starve);
  assign w_sel_i = aresetn & i_req & ~w_sel_d;

  assign tcm_req   = aresetn & (i_req | d_req) & ~w_full;
  assign tcm_we    = w_sel_d & d_we;
  assign tcm_be    = w_sel_d ? d_be    : (w_sel_i ? 4'hF   : 4'h0);
  assign tcm_addr  = w_sel_d ? d_addr  : (w_sel_i ? i_addr : 32'h0);
  assign tcm_wdata = w_sel_d ? d_wdata : 32'h0;

  assign w_hs  = tcm_req & tcm_gnt;
  assign i_gnt = w_hs & w_sel_i;
  assign d_gnt = w_hs & w_sel_d;

  assign w_pop      = aresetn & tcm_rvalid & ~w_empty;
  assign w_spurious = tcm_rvalid & w_empty;
  assign i_rvalid   = w_pop & (w_head == REQ_I);
  assign d_rvalid   = w_pop & (w_head == REQ_D);
  assign i_rdata    = i_rvalid ? tcm_rdata : 32'h0;
  assign d_rdata    = d_rvalid ? tcm_rdata : 32'h0;
  assign rsp_err    = r_rsp_err;

  arb_id_fifo #(.DEPTH(OUTSTANDING)) u_id_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .i_push    (w_hs),
    .i_push_id (w_sel_d ? REQ_D : REQ_I),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rsp_err <= 1'b0;
    else if (w_spurious) r_rsp_err <= 1'b1;
  end

`ifdef ITCM_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] r_starve_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_starve_cnt <= '0;
    else if (d_gnt) r_starve_cnt <= '0;
    else if (d_req && r_starve_cnt != SC_W'(STARVE_LIMIT)) r_starve_cnt <= r_starve_cnt + 1'b1;
  end

  assign w_starve = (r_starve_cnt == SC_W'(STARVE_LIMIT));
`else
  assign w_starve = 1'b0;
`endif
endmodule

// File: tb/tb_itcm_arbiter.sv
// Randomized bench for itcm_arbiter: behavioural queue model, acting ITCM slave, directed cases.
module tb_itcm_arbiter;
  localparam int OUTSTANDING  = 2;
  localparam int STARVE_LIMIT = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        i_req = 0, d_req = 0, d_we = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0]  d_be = 0;
  logic        tcm_gnt = 0, tcm_rvalid = 0;
  logic [31:0] tcm_rdata = 0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, tcm_req, tcm_we, rsp_err;
  logic [31:0] i_rdata, d_rdata, tcm_addr, tcm_wdata;
  logic [3:0]  tcm_be;

  int tests = 0;
  int fails = 0;

  bit          exp_q [$];   // 0 = I, 1 = D, in grant order
  logic [31:0] slv_q [$];   // read data the ITCM still owes
  bit          m_err = 0;
  int          m_starve = 0;
  bit          g_i = 0, g_d = 0;
  bit          slv_auto = 0;

  always #5 aclk = ~aclk;

  itcm_arbiter #(.OUTSTANDING(OUTSTANDING), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .tcm_req(tcm_req), .tcm_we(tcm_we), .tcm_be(tcm_be), .tcm_addr(tcm_addr),
    .tcm_wdata(tcm_wdata), .tcm_gnt(tcm_gnt), .tcm_rvalid(tcm_rvalid), .tcm_rdata(tcm_rdata),
    .rsp_err(rsp_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Compare process: model expectations from the arbitration rules, checked mid-cycle.
  always @(negedge aclk) begin
    bit starve, sel_d, sel_i, ex_req, ex_hs, ex_irv, ex_drv, spur;
    if (!aresetn) begin
      chk("rst_tcm_req", tcm_req, 0);
      chk("rst_gnt", {i_gnt, d_gnt}, 0);
      chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
      chk("rst_rdata", i_rdata | d_rdata, 0);
      chk("rst_tcm_attr", tcm_addr | tcm_wdata | {27'd0, tcm_we, tcm_be}, 0);
      chk("rst_err", rsp_err, 0);
      exp_q.delete();
      m_err = 0; m_starve = 0; g_i = 0; g_d = 0;
    end else begin
`ifdef ITCM_ARB_STARVE_EN
      starve = (m_starve >= STARVE_LIMIT);
`else
      starve = 0;
`endif
      sel_d  = d_req && (!i_req || starve);
      sel_i  = i_req && !sel_d;
      ex_req = (i_req || d_req) && (exp_q.size() < OUTSTANDING);
      ex_hs  = ex_req && tcm_gnt;
      ex_irv = 0; ex_drv = 0; spur = 0;
      if (tcm_rvalid) begin
        if (exp_q.size() > 0) begin
          ex_irv = !exp_q[0];
          ex_drv = exp_q[0];
        end else spur = 1;
      end
      chk("tcm_req", tcm_req, ex_req);
      chk("i_gnt", i_gnt, ex_hs && sel_i);
      chk("d_gnt", d_gnt, ex_hs && sel_d);
      if (ex_req) begin
        chk("tcm_addr", tcm_addr, sel_d ? d_addr : i_addr);
        chk("tcm_we", tcm_we, sel_d && d_we);
        chk("tcm_be", tcm_be, sel_d ? d_be : 4'hF);
        chk("tcm_wdata", tcm_wdata, sel_d ? d_wdata : 32'h0);
      end
      chk("i_rvalid", i_rvalid, ex_irv);
      chk("d_rvalid", d_rvalid, ex_drv);
      chk("i_rdata", i_rdata, ex_irv ? tcm_rdata : 32'h0);
      chk("d_rdata", d_rdata, ex_drv ? tcm_rdata : 32'h0);
      chk("rsp_err", rsp_err, m_err);

      if (tcm_rvalid && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ex_hs) exp_q.push_back(sel_d);
      if (spur) m_err = 1;
      g_i = ex_hs && sel_i;
      g_d = ex_hs && sel_d;
      if (g_d) m_starve = 0;
      else if (d_req && m_starve < STARVE_LIMIT) m_starve++;
      if (slv_auto && tcm_req && tcm_gnt) slv_q.push_back($urandom);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) tick();
    aresetn = 1;
    tick();

    // I only: grant now, response next cycle.
    i_req = 1; i_addr = 32'h20000010; tcm_gnt = 1;
    @(negedge aclk);
    chk("t1_i_gnt", i_gnt, 1);
    chk("t1_addr", tcm_addr, 32'h20000010);
    tick();
    i_req = 0; tcm_gnt = 0; tcm_rvalid = 1; tcm_rdata = 32'hDEADBEEF;
    @(negedge aclk);
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    chk("t1_d_rvalid", d_rvalid, 0);
    tick();
    tcm_rvalid = 0;

    // Both request: I first, then D write; responses route I then D.
    i_req = 1; i_addr = 32'h20000020; tcm_gnt = 1;
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h20000004; d_wdata = 32'h12345678;
    @(negedge aclk);
    chk("t2_i_gnt", i_gnt, 1);
    chk("t2_d_gnt0", d_gnt, 0);
    tick();
    i_req = 0; tcm_rvalid = 1; tcm_rdata = 32'h0000AAAA;
    @(negedge aclk);
    chk("t2_d_gnt1", d_gnt, 1);
    chk("t2_tcm_be", tcm_be, 4'h3);
    chk("t2_tcm_wdata", tcm_wdata, 32'h12345678);
    chk("t2_i_rvalid", i_rvalid, 1);
    tick();
    d_req = 0; d_we = 0; tcm_gnt = 0; tcm_rdata = 32'h0;
    @(negedge aclk);
    chk("t2_d_rvalid", d_rvalid, 1);
    chk("t2_i_rvalid_off", i_rvalid, 0);
    tick();
    tcm_rvalid = 0;

    // Outstanding limit: two grants, then blocked until the first response.
    i_req = 1; i_addr = 32'h20000100; tcm_gnt = 1;
    @(negedge aclk); chk("t3_gnt1", i_gnt, 1);
    tick(); i_addr = 32'h20000104;
    @(negedge aclk); chk("t3_gnt2", i_gnt, 1);
    tick(); i_addr = 32'h20000108;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      chk("t3_full_req", tcm_req, 0);
      chk("t3_full_gnt", i_gnt, 0);
      tick();
    end
    tcm_rvalid = 1; tcm_rdata = 32'h1;
    @(negedge aclk);
    chk("t3_pop_req", tcm_req, 0);
    chk("t3_pop_rv", i_rvalid, 1);
    tick(); tcm_rvalid = 0;
    @(negedge aclk); chk("t3_gnt3", i_gnt, 1);
    tick(); i_req = 0; tcm_rvalid = 1;
    repeat (2) begin
      @(negedge aclk); chk("t3_drain", i_rvalid, 1);
      tick();
    end
    tcm_rvalid = 0;

    // 10 back-to-back fetches with push and pop together.
    cnt = 0;
    for (int c = 0; c <= 10; c++) begin
      i_req = (c < 10); i_addr = 32'h20000200 + 32'(c * 4); tcm_gnt = 1;
      tcm_rvalid = (c > 0); tcm_rdata = 32'(c);
      @(negedge aclk);
      if (c < 10) chk("t4_i_gnt", i_gnt, 1);
      if (i_rvalid) cnt++;
      tick();
    end
    tcm_rvalid = 0; tcm_gnt = 0;
    chk("t4_rsp_count", cnt, 10);
    chk("t4_no_err", rsp_err, 0);

    // Spurious response: no port rvalid, sticky error until reset.
    tcm_rvalid = 1; tcm_rdata = 32'hBAD0BAD0;
    @(negedge aclk);
    chk("t5_rv", {i_rvalid, d_rvalid}, 0);
    tick(); tcm_rvalid = 0;
    repeat (3) begin
      @(negedge aclk); chk("t5_err_sticky", rsp_err, 1);
      tick();
    end
    aresetn = 0;
    @(negedge aclk); chk("t5_err_cleared", rsp_err, 0);
    tick(); aresetn = 1;
    tick();

`ifdef ITCM_ARB_STARVE_EN
    // Starvation guard: D forced through on the 9th denied cycle.
    i_req = 1; i_addr = 32'h20000300; tcm_gnt = 1;
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h20000400;
    for (int c = 1; c <= 10; c++) begin
      @(negedge aclk);
      chk("t6_d_gnt", d_gnt, c == 9);
      chk("t6_i_gnt", i_gnt, c != 9);
      tick();
      if (c == 9) d_req = 0;
      tcm_rvalid = 1;
    end
    i_req = 0;
    @(negedge aclk); tick();
    tcm_rvalid = 0; tcm_gnt = 0;
    tick();
`endif

    // Randomized phase with the bench acting as the ITCM.
    slv_auto = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!i_req || g_i) begin
        i_req = $urandom_range(0, 1); i_addr = $urandom;
      end
      if (!d_req || g_d) begin
        d_req = $urandom_range(0, 1); d_we = $urandom_range(0, 1);
        d_be = 4'($urandom); d_addr = $urandom; d_wdata = $urandom;
      end
      tcm_gnt = ($urandom_range(0, 3) != 0);
      if (slv_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        tcm_rvalid = 1; tcm_rdata = slv_q.pop_front();
      end else begin
        tcm_rvalid = 0; tcm_rdata = $urandom;
      end
      if (cyc == 1500) aresetn = 0;
      if (cyc == 1502) aresetn = 1;
      tick();
    end
    i_req = 0; d_req = 0; tcm_gnt = 0;
    for (int k = 0; k < 20 && slv_q.size() > 0; k++) begin
      tcm_rvalid = 1; tcm_rdata = slv_q.pop_front();
      tick();
    end
    tcm_rvalid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
